// File: rtl/vector_accumulator_if.sv
// Handshake bundle for the vector accumulator: one input vector stream and one result stream.
interface vector_accumulator_if #(
  parameter int unsigned VLEN = 3
);
  localparam int unsigned VW = 32 * VLEN;

  logic [VW-1:0] in_vec;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] out_vec;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_vec, out_valid
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_vec, out_valid
  );
endinterface

// File: rtl/vector_accumulator.sv
// Sums NUM_TERMS float32 vectors (one per accepted beat) element-wise and presents the total
// on a valid/ready output; round-to-nearest-even, subnormals and IEEE special values supported.
module vector_accumulator #(
  parameter int unsigned VLEN      = 3,
  parameter int unsigned NUM_TERMS = 4
) (
  input logic               clk,
  input logic               rst,
  vector_accumulator_if.slave bus
);
  localparam int unsigned VW = 32 * VLEN;
  localparam int unsigned CW = $clog2(NUM_TERMS + 1);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] OUTPUT = 1'b1;

  // Single-precision add, round-to-nearest-even, NaN results canonicalised to 7FC00000.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]     x, y, r;
    logic [23:0]     mx, my;
    logic [7:0]      ex, ey, d;
    logic [26:0]     ys;
    logic [27:0]     s;
    logic [8:0]      e, sh;
    logic [30:0]     mag;
    logic            sticky, rnd, found, a_nan, b_nan, a_inf, b_inf;
    int unsigned     lz;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    r = 32'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      r = 32'h7FC0_0000;
    end else if (a_inf) begin
      r = a;
    end else if (b_inf) begin
      r = b;
    end else begin
      if (a[30:0] >= b[30:0]) begin
        x = a; y = b;
      end else begin
        x = b; y = a;
      end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx = {x[30:23] != 8'd0, x[22:0]};
      my = {y[30:23] != 8'd0, y[22:0]};
      d  = ex - ey;
      // Align the smaller operand, folding shifted-out bits into a sticky LSB.
      if (d >= 8'd27) begin
        ys     = 27'd0;
        sticky = |my;
      end else begin
        ys     = {my, 3'b000} >> d;
        sticky = |({my, 3'b000} & ((27'd1 << d) - 27'd1));
      end
      ys[0] = ys[0] | sticky;
      if (x[31] == y[31]) s = {1'b0, mx, 3'b000} + {1'b0, ys};
      else                s = {1'b0, mx, 3'b000} - {1'b0, ys};
      e = {1'b0, ex};
      if (s == 28'd0) begin
        r = {x[31] & y[31], 31'd0};
      end else begin
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 9'd1;
        end else begin
          lz    = 0;
          found = 1'b0;
          for (int i = 26; i >= 0; i--) begin
            if (!found) begin
              if (s[i]) found = 1'b1;
              else      lz = lz + 1;
            end
          end
          // Normalisation stops at the minimum exponent, leaving a subnormal.
          sh = 9'(lz);
          if (sh > e - 9'd1) sh = e - 9'd1;
          s = s << sh;
          e = e - sh;
        end
        if (e >= 9'd255) begin
          r = {x[31], 8'hFF, 23'd0};
        end else begin
          rnd = s[2] & (s[1] | s[0] | s[3]);
          mag = {(s[26] ? e[7:0] : 8'd0), s[25:3]} + 31'(rnd);
          r   = {x[31], mag};
        end
      end
    end
    return r;
  endfunction

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [VW-1:0] acc_q, acc_d;
  logic [VW-1:0] sum_c;
  logic          in_ready_q, out_valid_q;

  for (genvar i = 0; i < VLEN; i++) begin : g_lane
    assign sum_c[32*i +: 32] = fp_add(acc_q[32*i +: 32], bus.in_vec[32*i +: 32]);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid && in_ready_q) begin
          // First term is loaded raw so signed zeros survive untouched.
          acc_d = (count_q == '0) ? bus.in_vec : sum_c;
          if (count_q == CW'(NUM_TERMS - 1)) begin
            count_d = '0;
            state_d = OUTPUT;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        if (out_valid_q && bus.out_ready) state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == OUTPUT);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = acc_q;
endmodule

// File: tb/tb_vector_accumulator.sv
// Directed plus randomized bench for vector_accumulator; expected sums come from exact
// integer arithmetic on quarter-unit values, encoded to float32 by the bench.
module tb_vector_accumulator;
  localparam int unsigned VLEN = 3;
  localparam int unsigned VW   = 32 * VLEN;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vector_accumulator_if #(.VLEN(VLEN)) bus4 ();
  vector_accumulator_if #(.VLEN(VLEN)) bus1 ();

  vector_accumulator #(.VLEN(VLEN), .NUM_TERMS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  vector_accumulator #(.VLEN(VLEN), .NUM_TERMS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep3(input logic [31:0] x);
    return {x, x, x};
  endfunction

  // Exact float32 encoding of q/4 for |q| < 2^24.
  function automatic logic [31:0] enc(input int q);
    logic [31:0] m, r;
    int p;
    if (q == 0) return 32'd0;
    m = (q < 0) ? 32'(-q) : 32'(q);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    r[31]    = (q < 0);
    r[30:23] = 8'(p - 2 + 127);
    r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  task automatic send4(input logic [VW-1:0] v, input int gap);
    int n;
    bus4.in_valid = 1'b0;
    repeat (gap) tick();
    bus4.in_vec   = v;
    bus4.in_valid = 1'b1;
    n = 0;
    while (!bus4.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", VW'(bus4.in_ready), VW'(1));
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic get4(input string tag, input logic [VW-1:0] exp, input int hold);
    int n;
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, VW'(bus4.out_valid), VW'(1));
    check(tag, bus4.out_vec, exp);
    bus4.out_ready = 1'b0;
    repeat (hold) begin
      tick();
      check({tag, "_hold"}, bus4.out_vec, exp);
    end
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check({tag, "_drop"}, VW'(bus4.out_valid), VW'(0));
  endtask

  initial begin
    logic [VW-1:0] v, e;
    logic [VW-1:0] vals [4];
    int q, sum [3];
    int idx, got, cyc;
    logic acc;

    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_vec = '0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_vec = '0; bus1.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", VW'(bus4.out_valid), VW'(0));
    check("rst_in_ready", VW'(bus4.in_ready), VW'(1));
    check("rst_out_vec", bus4.out_vec, '0);
    check("rst1_out_valid", VW'(bus1.out_valid), VW'(0));

    // Basic sum with back-to-back beats and one-cycle latency.
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) check("basic_not_early", VW'(bus4.out_valid), VW'(0));
      send4(rep3(enc(4 * i)), 0);
    end
    check("basic_latency", VW'(bus4.out_valid), VW'(1));
    check("basic_in_ready_low", VW'(bus4.in_ready), VW'(0));
    get4("basic", rep3(32'h4120_0000), 0);

    // Elements are independent lanes.
    repeat (4) send4({32'h3F00_0000, 32'hBF80_0000, 32'h3F80_0000}, 0);
    get4("lanes", {32'h4000_0000, 32'hC080_0000, 32'h4080_0000}, 0);

    // Backpressure: 7.0 offered during the stall must be ignored.
    repeat (4) send4(rep3(32'h4000_0000), 0);
    bus4.out_ready = 1'b0;
    bus4.in_vec    = rep3(32'h40E0_0000);
    bus4.in_valid  = 1'b1;
    repeat (5) begin
      tick();
      check("stall_vec", bus4.out_vec, rep3(32'h4100_0000));
      check("stall_in_ready", VW'(bus4.in_ready), VW'(0));
    end
    bus4.in_valid = 1'b0;
    get4("stall", rep3(32'h4100_0000), 0);
    repeat (4) send4(rep3(32'h3F80_0000), 0);
    get4("after_stall", rep3(32'h4080_0000), 0);

    // Input bubbles do not advance the count.
    for (int i = 1; i <= 4; i++) send4(rep3(enc(4 * i)), int'($urandom_range(1, 3)));
    get4("bubbles", rep3(32'h4120_0000), 0);

    // Reset mid-group discards the partial sum.
    send4(rep3(32'h3F80_0000), 0);
    send4(rep3(32'h3F80_0000), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", VW'(bus4.out_valid), VW'(0));
    check("midrst_in_ready", VW'(bus4.in_ready), VW'(1));
    for (int i = 0; i < 3; i++) begin
      send4(rep3(32'h4000_0000), 0);
      check("midrst_no_early", VW'(bus4.out_valid), VW'(0));
    end
    send4(rep3(32'h4000_0000), 0);
    get4("midrst", rep3(32'h4100_0000), 0);

    // Randomized groups against exact integer sums.
    for (int g = 0; g < 15; g++) begin
      for (int k = 0; k < 3; k++) sum[k] = 0;
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 3; k++) begin
          q = int'($urandom_range(800)) - 400;
          sum[k] += q;
          v[32*k +: 32] = enc(q);
        end
        send4(v, int'($urandom_range(0, 2)));
      end
      for (int k = 0; k < 3; k++) e[32*k +: 32] = enc(sum[k]);
      get4("rand", e, int'($urandom_range(0, 3)));
    end

    // NUM_TERMS=1: bit-exact pass-through, one result every two cycles.
    vals[0] = {32'h0000_0001, 32'h8000_0000, 32'hBF80_0000};
    vals[1] = rep3(32'h8000_0000);
    vals[2] = {$urandom, $urandom, $urandom};
    vals[3] = {$urandom, $urandom, $urandom};
    bus1.out_ready = 1'b1;
    bus1.in_vec    = vals[0];
    bus1.in_valid  = 1'b1;
    idx = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      acc = bus1.in_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) bus1.in_vec = vals[idx];
        else         bus1.in_valid = 1'b0;
      end
      if (bus1.out_valid) begin
        check("nt1_vec", bus1.out_vec, vals[got]);
        got++;
      end
    end
    bus1.in_valid = 1'b0;
    check("nt1_count", VW'(got), VW'(4));
    check("nt1_cycles", VW'(cyc), VW'(7));
    tick();
    check("nt1_drop", VW'(bus1.out_valid), VW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
